dec_7seg: RTL and testbench



---
 rtl/dec_7seg.sv | 92 +++++++++
 tb/tb_dec_7seg.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/dec_7seg.sv
// dec_7seg: registered hex-to-seven-segment decoder with blanking, lamp test
// and decimal-point pass-through for the multiplexed 8-digit LED display.
//
// Configuration macro:
//   DEC_7SEG_ACTIVE_LOW_EN  defined   -> seg/dp active-low (0 = lit), common-anode wiring
//                           undefined -> seg/dp active-high (1 = lit)
//
// Internally everything is computed as a logical "lit" pattern (1 = lit,
// bit order gfedcba). The physical polarity is applied just before the
// output register, so no combinational path reaches seg/dp.
module dec_7seg (
   input  logic       clk,
   input  logic       rst,
   input  logic       ce,
   input  logic [3:0] dig,
   input  logic       blank,
   input  logic       lamp_test,
   input  logic       dp_in,
   output logic [6:0] seg,
   output logic       dp
);

`ifdef DEC_7SEG_ACTIVE_LOW_EN
   localparam logic INV = 1'b1;
`else
   localparam logic INV = 1'b0;
`endif

   // Physical "all off" drive levels, used by reset.
   localparam logic [6:0] SEG_OFF = {7{INV}};
   localparam logic       DP_OFF  = INV;

   logic [6:0] pat_l;     // decoded logical pattern from dig
   logic [6:0] lit_l;     // logical pattern after lamp test / blank priority
   logic       dp_lit;    // logical decimal point after priority
   logic [6:0] seg_d, seg_q;
   logic       dp_d, dp_q;

   // Hex nibble to logical segment pattern; every value has a defined pattern.
   always_comb begin
      pat_l = 7'h00;
      unique case (dig)
         4'h0:    pat_l = 7'h3F;
         4'h1:    pat_l = 7'h06;
         4'h2:    pat_l = 7'h5B;
         4'h3:    pat_l = 7'h4F;
         4'h4:    pat_l = 7'h66;
         4'h5:    pat_l = 7'h6D;
         4'h6:    pat_l = 7'h7D;
         4'h7:    pat_l = 7'h07;
         4'h8:    pat_l = 7'h7F;
         4'h9:    pat_l = 7'h6F;
         4'hA:    pat_l = 7'h77;
         4'hB:    pat_l = 7'h7C;
         4'hC:    pat_l = 7'h39;
         4'hD:    pat_l = 7'h5E;
         4'hE:    pat_l = 7'h79;
         4'hF:    pat_l = 7'h71;
         default: pat_l = 7'h00;
      endcase
   end

   // Resolve lamp test over blank over normal decode, then apply polarity.
   always_comb begin
      lit_l  = pat_l;
      dp_lit = dp_in;
      if (lamp_test) begin
         lit_l  = 7'h7F;
         dp_lit = 1'b1;
      end else if (blank) begin
         lit_l  = 7'h00;
         dp_lit = 1'b0;
      end
      seg_d = lit_l ^ {7{INV}};
      dp_d  = dp_lit ^ INV;
   end

   // Output registers: reset wins over ce; ce=0 holds the last drive.
   always_ff @(posedge clk) begin
      if (rst) begin
         seg_q <= SEG_OFF;
         dp_q  <= DP_OFF;
      end else if (ce) begin
         seg_q <= seg_d;
         dp_q  <= dp_d;
      end
   end

   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_dec_7seg.sv
// tb_dec_7seg: directed, table-driven bench for dec_7seg. Expected values are
// written as logical patterns (1 = lit) and converted to the configured drive
// polarity, so the same bench covers both builds of DEC_7SEG_ACTIVE_LOW_EN.
module tb_dec_7seg;

`ifdef DEC_7SEG_ACTIVE_LOW_EN
   localparam logic [6:0] INV = 7'h7F;
`else
   localparam logic [6:0] INV = 7'h00;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ce = 1'b0;
   logic [3:0] dig = 4'h0;
   logic       blank = 1'b0;
   logic       lamp_test = 1'b0;
   logic       dp_in = 1'b0;
   logic [6:0] seg;
   logic       dp;

   int n_checks = 0;
   int n_fail = 0;

   // Expected {seg, dp} physical values, consumed in order by check_out.
   logic [7:0] exp_q[$];

   typedef struct {
      logic       rst;
      logic       ce;
      logic [3:0] dig;
      logic       blank;
      logic       lamp;
      logic       dp_in;
      logic [6:0] exp_l;
      logic       exp_dp_l;
   } vec_t;

   vec_t vecs[14];

   // Hand-copied decode table (logical, gfedcba).
   logic [6:0] hex_pat[16];

   dec_7seg dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .dig       (dig),
      .blank     (blank),
      .lamp_test (lamp_test),
      .dp_in     (dp_in),
      .seg       (seg),
      .dp        (dp)
   );

   // Clock
   always #5 clk = ~clk;

   // Drive inputs on the falling edge, let one rising edge pass, sample 1 ns later.
   task automatic step(input logic r, input logic c, input logic [3:0] d,
                       input logic b, input logic l, input logic p);
      @(negedge clk);
      rst       = r;
      ce        = c;
      dig       = d;
      blank     = b;
      lamp_test = l;
      dp_in     = p;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_l(input logic [6:0] lit, input logic dpl);
      exp_q.push_back({lit ^ INV, dpl ^ INV[0]});
   endtask

   task automatic check_out(input string name);
      logic [7:0] e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: no expected value queued (seg=%h dp=%b)", name, seg, dp);
      end else begin
         e = exp_q.pop_front();
         if ({seg, dp} !== e) begin
            n_fail++;
            $display("FAIL %s: seg=%h dp=%b, required seg=%h dp=%b",
                     name, seg, dp, e[7:1], e[0]);
         end
      end
   endtask

   initial begin
      hex_pat = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

      //            rst   ce    dig   blank lamp  dp_in exp_l  exp_dp
      vecs[0]  = '{1'b1, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0}; // reset
      vecs[1]  = '{1'b1, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0}; // reset held
      vecs[2]  = '{1'b0, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 7'h7F, 1'b0}; // first decode
      vecs[3]  = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b1, 1'b0, 7'h7F, 1'b1}; // lamp over blank
      vecs[4]  = '{1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 7'h00, 1'b0}; // blank
      vecs[5]  = '{1'b0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 7'h06, 1'b0}; // normal
      vecs[6]  = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 7'h6D, 1'b1}; // dp lit
      vecs[7]  = '{1'b0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 7'h6D, 1'b0}; // dp off
      vecs[8]  = '{1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 7'h00, 1'b0}; // blank kills dp
      vecs[9]  = '{1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 7'h7F, 1'b1}; // lamp lights dp
      vecs[10] = '{1'b0, 1'b0, 4'hC, 1'b1, 1'b0, 1'b0, 7'h7F, 1'b1}; // ce=0 holds
      vecs[11] = '{1'b1, 1'b0, 4'hC, 1'b0, 1'b1, 1'b1, 7'h00, 1'b0}; // rst over ce=0
      vecs[12] = '{1'b0, 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 7'h00, 1'b0}; // hold reset level
      vecs[13] = '{1'b0, 1'b1, 4'hC, 1'b0, 1'b0, 1'b1, 7'h39, 1'b1}; // resume

      for (int i = 0; i < 14; i++) begin
         step(vecs[i].rst, vecs[i].ce, vecs[i].dig, vecs[i].blank, vecs[i].lamp, vecs[i].dp_in);
         expect_l(vecs[i].exp_l, vecs[i].exp_dp_l);
         check_out($sformatf("vec%0d", i));
      end

      // Full sweep 0..F, one digit per cycle.
      for (int d = 0; d < 16; d++) begin
         step(1'b0, 1'b1, 4'(d), 1'b0, 1'b0, 1'b0);
         expect_l(hex_pat[d], 1'b0);
         check_out($sformatf("sweep_%h", d));
      end

      // Enable hold: load 3, then ce=0 with dig=7 for 5 cycles, then ce=1.
      step(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
      expect_l(7'h4F, 1'b0);
      check_out("hold_load3");
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0);
         expect_l(7'h4F, 1'b0);
         check_out($sformatf("hold_%0d", k));
      end
      step(1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
      expect_l(7'h07, 1'b0);
      check_out("hold_release7");

      // Scan integration: nibbles of 0x89ABCDEF, low nibble first, ce pulsed
      // once per nibble with an idle ce=0 cycle in between.
      begin
         logic [31:0] word;
         logic [3:0]  nib;
         logic [6:0]  scan_exp[8];
         word = 32'h89AB_CDEF;
         scan_exp = '{7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F};
         for (int s = 0; s < 8; s++) begin
            nib = word[4*s +: 4];
            step(1'b0, 1'b1, nib, 1'b0, 1'b0, 1'b0);
            expect_l(scan_exp[s], 1'b0);
            check_out($sformatf("scan_%0d", s));
            step(1'b0, 1'b0, 4'(s), 1'b1, 1'b0, 1'b1);
            expect_l(scan_exp[s], 1'b0);
            check_out($sformatf("scan_idle_%0d", s));
         end
      end

      // Mid-stream reset with everything else asserted blanks the display.
      step(1'b1, 1'b1, 4'h8, 1'b0, 1'b1, 1'b1);
      expect_l(7'h00, 1'b0);
      check_out("midstream_rst");
      step(1'b0, 1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
      expect_l(7'h77, 1'b0);
      check_out("after_rst_A");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
